vga_sprite_render: RTL and testbench
====================================

Name: vga_sprite_render

Overview:
- Pixel-generation stage directly downstream of the VGA sync generator, in the same 25 MHz pixel-clock domain.
- Consumes the generator's raw counters, registered display-area flag and registered active-low syncs.
- Produces 12-bit RGB: a 32x32 checkerboard background with one bouncing outlined box sprite over it.
- Sprite position updates once per frame, during vertical blanking, so there is no tearing. Syncs are re-registered so they stay aligned with the RGB output.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SPR_W, 16, sprite width in pixels (2..64)
SPR_H, 16, sprite height in pixels (2..64)
INIT_X, 100, sprite X after reset
INIT_Y, 50, sprite Y after reset
STEP, 2, pixels moved per axis per frame (1..SPR_W)
BG_A, 12'h222, checker colour when X[5]^Y[5]==0
BG_B, 12'h444, checker colour when X[5]^Y[5]==1
FILL, 12'h0F0, sprite interior colour
OUTLINE, 12'hFFF, sprite outline colour

Ports:
CLK_25  in  1  pixel clock
Reset_N  in  1  asynchronous active-low reset
CounterX  in  10  raw X counter (pixel for cycle t)
CounterY  in  10  raw Y counter (pixel for cycle t)
inDisplayArea  in  1  display flag for the cycle-t pixel, valid at t+1
vga_h_sync_in  in  1  active-low hsync, aligned with inDisplayArea
vga_v_sync_in  in  1  active-low vsync, aligned with inDisplayArea
move_en  in  1  1 = sprite moves each frame, 0 = frozen
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_h_sync  out  1  hsync delayed to align with RGB
vga_v_sync  out  1  vsync delayed to align with RGB
frame_cnt  out  16  frames seen since reset, wraps
bounce  out  1  one-cycle pulse when the sprite hits any edge

Behaviour:
- Reset (async, Reset_N=0):
  - RGB=0; vga_h_sync=vga_v_sync=1; frame_cnt=0; bounce=0.
  - Sprite x=INIT_X, y=INIT_Y; dx=+1, dy=+1; FSM in WAIT_FRAME; vsync edge register=1.
  - Mid-frame reset must produce clean black/idle outputs on the next edge after release.
- Pipeline:
  - Stage A registers CounterX/CounterY (cx, cy), which aligns them with inDisplayArea and the syncs.
  - Stage B registers RGB, both syncs and the display flag.
  - Output latency = 1 cycle after the sync/display inputs, 2 cycles after the counters.
- Pixel select (stage B input), in priority order:
  1. inDisplayArea=0: RGB=0.
  2. Sprite hit, defined as x<=cx<x+SPR_W and y<=cy<y+SPR_H using 11-bit compare, no wrap:
     - lx=cx-x, ly=cy-y; outline when lx==0 or lx==SPR_W-1 or ly==0 or ly==SPR_H-1.
     - Outline pixels use OUTLINE; all other hit pixels use FILL.
  3. Otherwise background: BG_A/BG_B by cx[5]^cy[5].
  - RGB = {r,g,b} = colour[11:8], [7:4], [3:0].
- Frame event: falling edge of vga_v_sync_in (registered previous=1, current=0), i.e. start of the vsync pulse inside vertical blanking.
- Motion FSM:
  - WAIT_FRAME: on frame event, frame_cnt += 1 (wraps 0xFFFF to 0). Go to UPD_X if move_en=1, else stay.
  - UPD_X (1 cycle), +1 direction:
    - If x+STEP+SPR_W > H_ACTIVE: x=H_ACTIVE-SPR_W, dx=-1, bounce.
    - Else x+=STEP.
  - UPD_X, -1 direction:
    - If x < STEP: x=0, dx=+1, bounce.
    - Else x-=STEP.
  - UPD_X always goes to UPD_Y.
  - UPD_Y: same rules with V_ACTIVE, SPR_H, y, dy. Then go to WAIT_FRAME.
  - bounce pulses for 1 cycle in each update state that clamps. A corner hit gives two pulses on consecutive cycles.
  - Arithmetic is 11-bit so sums never overflow. Invariant: 0<=x<=H_ACTIVE-SPR_W and 0<=y<=V_ACTIVE-SPR_H at all times.
  - Position registers change only in UPD_X/UPD_Y, which are always inside vertical blanking. No visible line ever sees a half-updated position.
  - move_en is sampled only on the frame event. Deasserting it mid-update completes the current X/Y pair.
  - A frame event arriving while in UPD_X/UPD_Y is impossible at legal timing; it is ignored.

Test Plan:
- Reset release, X=0..799 scan of line 0: first output at latency 2 from counters. Pixels 0-31 = 12'h222, 32-63 = 12'h444, RGB=0 for X>=640, hsync low for exactly 96 cycles aligned with RGB.
- Line y=50, x=100..115 (default sprite): pixel 100 and pixel 115 = FFF. Line 51 pixels 101-114 = 0F0. Pixel 116 reverts to background.
- 10 frames with move_en=1: x=120, y=70, frame_cnt=10, no bounce.
- Force start x=622 (dx=+1), 1 frame: x=624 with no bounce. Next frame: x=624 clamped, dx=-1, bounce pulses once. Following frame: x=622.
- Corner: x=0, y=0, dx=dy=-1: after 1 frame x=0, y=0, dx=dy=+1, bounce high on two consecutive cycles.
- move_en=0 for 5 frames: position frozen, frame_cnt +5. Assert Reset_N=0 mid-line: RGB=0 and syncs=1 immediately; after release x=100, y=50.

Source files
------------

// File: rtl/vga_sprite_render_if.sv
// Video bus between the sync generator (master) and the sprite renderer (slave).
// It carries the raw counters and syncs into the renderer, and the aligned RGB and syncs back out.
interface vga_sprite_render_if;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       inDisplayArea;
  logic       vga_h_sync_in;
  logic       vga_v_sync_in;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_h_sync;
  logic       vga_v_sync;

  modport master (
    output CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
    input  vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
  );

  modport slave (
    input  CounterX, CounterY, inDisplayArea, vga_h_sync_in, vga_v_sync_in,
    output vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync
  );
endinterface

// File: rtl/vga_sprite_render.sv
// Pixel stage behind the VGA sync generator: checkerboard background plus a bouncing outlined box.
// The box moves once per frame during vertical blanking; the syncs are re-timed to match the RGB output.
module vga_sprite_render #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned SPR_W    = 16,
  parameter int unsigned SPR_H    = 16,
  parameter int unsigned INIT_X   = 100,
  parameter int unsigned INIT_Y   = 50,
  parameter int unsigned STEP     = 2,
  parameter logic [11:0] BG_A     = 12'h222,
  parameter logic [11:0] BG_B     = 12'h444,
  parameter logic [11:0] FILL     = 12'h0F0,
  parameter logic [11:0] OUTLINE  = 12'hFFF
) (
  input  logic                CLK_25,
  input  logic                Reset_N,
  vga_sprite_render_if.slave  vif,
  input  logic                move_en,
  output logic [15:0]         frame_cnt,
  output logic                bounce
);

  localparam int unsigned PW = 11;
  localparam logic [PW-1:0] H_LIM   = PW'(H_ACTIVE);
  localparam logic [PW-1:0] V_LIM   = PW'(V_ACTIVE);
  localparam logic [PW-1:0] SW      = PW'(SPR_W);
  localparam logic [PW-1:0] SH      = PW'(SPR_H);
  localparam logic [PW-1:0] STP     = PW'(STEP);
  localparam logic [PW-1:0] X_MAX   = PW'(H_ACTIVE - SPR_W);
  localparam logic [PW-1:0] Y_MAX   = PW'(V_ACTIVE - SPR_H);
  localparam logic [PW-1:0] X_RESET = PW'(INIT_X);
  localparam logic [PW-1:0] Y_RESET = PW'(INIT_Y);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    UPD_X      = 2'd1,
    UPD_Y      = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    cx_q, cx_d, cy_q, cy_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          vs_prev_q, vs_prev_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  logic          dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          bounce_q, bounce_d;

  logic [PW-1:0] cx_w, cy_w, lx, ly;
  logic          hit, outline, frame_ev;

  // Stage A aligns the counters with the display flag; stage B picks the colour.
  always_comb begin
    cx_d    = vif.CounterX;
    cy_d    = vif.CounterY;
    hs_d    = vif.vga_h_sync_in;
    vs_d    = vif.vga_v_sync_in;
    cx_w    = PW'(cx_q);
    cy_w    = PW'(cy_q);
    lx      = cx_w - x_q;
    ly      = cy_w - y_q;
    hit     = (cx_w >= x_q) && (cx_w < x_q + SW) && (cy_w >= y_q) && (cy_w < y_q + SH);
    outline = (lx == PW'(0)) || (lx == SW - PW'(1)) || (ly == PW'(0)) || (ly == SH - PW'(1));
    if (!vif.inDisplayArea) begin
      rgb_d = 12'h000;
    end else if (hit) begin
      rgb_d = outline ? OUTLINE : FILL;
    end else begin
      rgb_d = (cx_q[5] ^ cy_q[5]) ? BG_B : BG_A;
    end
  end

  assign frame_ev  = vs_prev_q & ~vif.vga_v_sync_in;
  assign vs_prev_d = vif.vga_v_sync_in;

  // Motion FSM: position only changes in the two update states, which fall inside vertical blanking.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    frame_cnt_d = frame_cnt_q;
    bounce_d    = 1'b0;
    unique case (state_q)
      WAIT_FRAME: begin
        if (frame_ev) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (move_en) state_d = UPD_X;
        end
      end
      UPD_X: begin
        if (!dx_neg_q) begin
          if (x_q + STP + SW > H_LIM) begin
            x_d      = X_MAX;
            dx_neg_d = 1'b1;
            bounce_d = 1'b1;
          end else begin
            x_d = x_q + STP;
          end
        end else if (x_q < STP) begin
          x_d      = PW'(0);
          dx_neg_d = 1'b0;
          bounce_d = 1'b1;
        end else begin
          x_d = x_q - STP;
        end
        state_d = UPD_Y;
      end
      UPD_Y: begin
        if (!dy_neg_q) begin
          if (y_q + STP + SH > V_LIM) begin
            y_d      = Y_MAX;
            dy_neg_d = 1'b1;
            bounce_d = 1'b1;
          end else begin
            y_d = y_q + STP;
          end
        end else if (y_q < STP) begin
          y_d      = PW'(0);
          dy_neg_d = 1'b0;
          bounce_d = 1'b1;
        end else begin
          y_d = y_q - STP;
        end
        state_d = WAIT_FRAME;
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge CLK_25 or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= WAIT_FRAME;
      cx_q        <= '0;
      cy_q        <= '0;
      rgb_q       <= 12'h000;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      vs_prev_q   <= 1'b1;
      x_q         <= X_RESET;
      y_q         <= Y_RESET;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      frame_cnt_q <= 16'd0;
      bounce_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      frame_cnt_q <= frame_cnt_d;
      bounce_q    <= bounce_d;
    end
  end

  assign vif.vga_r      = rgb_q[11:8];
  assign vif.vga_g      = rgb_q[7:4];
  assign vif.vga_b      = rgb_q[3:0];
  assign vif.vga_h_sync = hs_q;
  assign vif.vga_v_sync = vs_q;
  assign frame_cnt      = frame_cnt_q;
  assign bounce         = bounce_q;

endmodule

// File: tb/tb_vga_sprite_render.sv
// Randomized scoreboard bench for vga_sprite_render: a default 640x480 instance and a
// square 64x64 instance whose box travels diagonally and so clamps on both axes at once.
module tb_vga_sprite_render;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic move_en = 1'b1;
  logic [15:0] fc0, fc1;
  logic bo0, bo1;

  always #20 clk = ~clk;

  vga_sprite_render_if if0 ();
  vga_sprite_render_if if1 ();

  vga_sprite_render u_dut0 (
    .CLK_25(clk), .Reset_N(rst_n), .vif(if0), .move_en(move_en), .frame_cnt(fc0), .bounce(bo0)
  );

  vga_sprite_render #(
    .H_ACTIVE(64), .V_ACTIVE(64), .INIT_X(4), .INIT_Y(4)
  ) u_dut1 (
    .CLK_25(clk), .Reset_N(rst_n), .vif(if1), .move_en(move_en), .frame_cnt(fc1), .bounce(bo1)
  );

  typedef struct packed {
    logic [11:0] rgb0;
    logic [11:0] rgb1;
    logic        hs;
    logic        vs;
    logic [15:0] fc;
    logic        b0;
    logic        b1;
  } exp_t;

  exp_t sb [$];
  bit   bq0 [$];
  bit   bq1 [$];

  int nchk = 0;
  int nerr = 0;
  bit mon_en = 1'b0;
  int me_mode = 0;

  // Reference model: box position per instance and the frame count.
  int mx [2];
  int my [2];
  bit mxn [2];
  bit myn [2];
  int mfc;

  // Inputs of the previous driven pixel; display flag and syncs lag the counters by one cycle.
  int p_x, p_y;
  bit p_de, p_hs, p_vs, last_vs;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int lim_h(int i);
    return (i == 0) ? 640 : 64;
  endfunction

  function automatic int lim_v(int i);
    return (i == 0) ? 480 : 64;
  endfunction

  function automatic logic [11:0] colour(int i, int x, int y, bit de);
    int lx, ly;
    if (!de) return 12'h000;
    lx = x - mx[i];
    ly = y - my[i];
    if (lx >= 0 && lx < 16 && ly >= 0 && ly < 16) begin
      if (lx == 0 || lx == 15 || ly == 0 || ly == 15) return 12'hFFF;
      return 12'h0F0;
    end
    return ((((x / 32) + (y / 32)) % 2) == 1) ? 12'h444 : 12'h222;
  endfunction

  function automatic void move_axis(input int lim, input int pos, input bit neg,
                                    output int npos, output bit nneg, output bit b);
    npos = pos;
    nneg = neg;
    b    = 1'b0;
    if (!neg) begin
      if (pos + 2 + 16 > lim) begin
        npos = lim - 16; nneg = 1'b1; b = 1'b1;
      end else begin
        npos = pos + 2;
      end
    end else begin
      if (pos < 2) begin
        npos = 0; nneg = 1'b0; b = 1'b1;
      end else begin
        npos = pos - 2;
      end
    end
  endfunction

  function automatic void model_reset();
    mx[0] = 100; my[0] = 50; mx[1] = 4; my[1] = 4;
    for (int i = 0; i < 2; i++) begin
      mxn[i] = 1'b0; myn[i] = 1'b0;
    end
    mfc = 0;
    bq0.delete(); bq1.delete();
    p_x = 0; p_y = 0; p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b1; last_vs = 1'b1;
  endfunction

  function automatic void model_frame();
    int  nx, ny;
    bit  nn, bx, by;
    mfc = (mfc + 1) % 65536;
    if (move_en) begin
      for (int i = 0; i < 2; i++) begin
        move_axis(lim_h(i), mx[i], mxn[i], nx, nn, bx); mx[i] = nx; mxn[i] = nn;
        move_axis(lim_v(i), my[i], myn[i], ny, nn, by); my[i] = ny; myn[i] = nn;
        if (i == 0) begin bq0.push_back(bx); bq0.push_back(by); end
        else        begin bq1.push_back(bx); bq1.push_back(by); end
      end
    end
  endfunction

  task automatic drive(int nx, int ny, bit nde, bit nhs, bit nvs);
    exp_t e;
    @(negedge clk);
    case (me_mode)
      0:       move_en = 1'b1;
      1:       move_en = ($urandom % 8) != 0;
      default: move_en = 1'b0;
    endcase
    if0.CounterX = 10'(nx);      if1.CounterX = 10'(nx);
    if0.CounterY = 10'(ny);      if1.CounterY = 10'(ny);
    if0.inDisplayArea = p_de;    if1.inDisplayArea = p_de;
    if0.vga_h_sync_in = p_hs;    if1.vga_h_sync_in = p_hs;
    if0.vga_v_sync_in = p_vs;    if1.vga_v_sync_in = p_vs;
    e.rgb0 = colour(0, p_x, p_y, p_de);
    e.rgb1 = colour(1, p_x, p_y, p_de);
    e.hs   = p_hs;
    e.vs   = p_vs;
    e.b0   = (bq0.size() > 0) ? bq0.pop_front() : 1'b0;
    e.b1   = (bq1.size() > 0) ? bq1.pop_front() : 1'b0;
    if (last_vs && !p_vs) model_frame();
    e.fc   = 16'(mfc);
    sb.push_back(e);
    last_vs = p_vs;
    p_x = nx; p_y = ny; p_de = nde; p_hs = nhs; p_vs = nvs;
  endtask

  task automatic scan(int y, int x0, int x1);
    for (int x = x0; x <= x1; x++) drive(x, y, x < 640, !(x >= 656 && x < 752), 1'b1);
  endtask

  task automatic rand_pixel();
    int x, y;
    case ($urandom % 4)
      0: begin x = mx[0] - 2 + int'($urandom_range(0, 19)); y = my[0] - 2 + int'($urandom_range(0, 19)); end
      1: begin x = mx[1] - 2 + int'($urandom_range(0, 19)); y = my[1] - 2 + int'($urandom_range(0, 19)); end
      2: begin x = int'($urandom_range(0, 127)); y = int'($urandom_range(0, 127)); end
      default: begin x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524)); end
    endcase
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    drive(x, y, ($urandom % 8) != 0, 1'(($urandom % 2)), 1'b1);
  endtask

  // One frame: four blanked vsync-low cycles, one blanked cycle, then visible pixels.
  task automatic frame(int npix);
    for (int i = 0; i < 4; i++) drive(int'($urandom_range(0, 799)), 490, 1'b0, 1'b1, 1'b0);
    drive(0, 492, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < npix; i++) rand_pixel();
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    if0.inDisplayArea = 1'b0; if1.inDisplayArea = 1'b0;
    if0.vga_h_sync_in = 1'b1; if1.vga_h_sync_in = 1'b1;
    if0.vga_v_sync_in = 1'b1; if1.vga_v_sync_in = 1'b1;
    #1;
    check("rst_rgb0", 32'({if0.vga_r, if0.vga_g, if0.vga_b}), 32'h0);
    check("rst_rgb1", 32'({if1.vga_r, if1.vga_g, if1.vga_b}), 32'h0);
    check("rst_hs", 32'({if0.vga_h_sync, if1.vga_h_sync}), 32'h3);
    check("rst_vs", 32'({if0.vga_v_sync, if1.vga_v_sync}), 32'h3);
    check("rst_fc", 32'({fc0, fc1}), 32'h0);
    check("rst_bounce", 32'({bo0, bo1}), 32'h0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: every cycle the oldest expectation is compared with what the DUTs present.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && sb.size() > 0) begin
        e = sb.pop_front();
        check("rgb0", 32'({if0.vga_r, if0.vga_g, if0.vga_b}), 32'(e.rgb0));
        check("rgb1", 32'({if1.vga_r, if1.vga_g, if1.vga_b}), 32'(e.rgb1));
        check("hsync", 32'({if0.vga_h_sync, if1.vga_h_sync}), 32'({e.hs, e.hs}));
        check("vsync", 32'({if0.vga_v_sync, if1.vga_v_sync}), 32'({e.vs, e.vs}));
        check("frame_cnt0", 32'(fc0), 32'(e.fc));
        check("frame_cnt1", 32'(fc1), 32'(e.fc));
        check("bounce0", 32'(bo0), 32'(e.b0));
        check("bounce1", 32'(bo1), 32'(e.b1));
      end
    end
  end

  initial begin
    if0.CounterX = '0; if0.CounterY = '0;
    if1.CounterX = '0; if1.CounterY = '0;
    do_reset();
    scan(0, 0, 799);
    scan(50, 96, 120);
    scan(51, 96, 120);
    me_mode = 0;
    for (int f = 0; f < 10; f++) frame(0);
    scan(70, 116, 140);
    scan(50, 96, 120);
    me_mode = 1;
    for (int f = 0; f < 700; f++) frame(30);
    me_mode = 2;
    for (int f = 0; f < 5; f++) frame(20);
    scan(my[0] + 1, mx[0] - 2, mx[0] + 6);
    do_reset();
    me_mode = 0;
    scan(50, 96, 120);
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
